// File: rtl/prng_pkg.sv
// Shared constants, FSM state type and LFSR step function for the PRNG stream.
package prng_pkg;

    localparam int LFSR_W = 32;

    // Feedback taps of the 32-bit Fibonacci LFSR
    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'd3515;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // One shift: move left, feed the XOR of the taps into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    endfunction

endpackage

// File: rtl/prng_stream_if.sv
// Output word stream of the PRNG.
//
// Handshake: a word moves from master to slave on every rising clock edge
// where dout_valid and dout_ready are both high. While dout_valid is high and
// dout_ready is low, the master keeps dout and dout_valid unchanged. The
// master never waits for dout_ready before raising dout_valid.
interface prng_stream_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/prng_lfsr32.sv
// 32-bit Fibonacci LFSR register with synchronous load and shift controls.
module prng_lfsr32 import prng_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              res,
    input  logic              shift,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] value
);

    // LFSR register: load wins over shift, otherwise hold
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            value <= SEED;
        end else if (load) begin
            value <= load_val;
        end else if (shift) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/prng_stream.sv
// PRNG word stream: warms up the LFSR, assembles OUT_W bits LSB first into a
// word and hands words out through a valid/ready register, parking one
// completed word in the assembly register when the consumer stalls.
module prng_stream import prng_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
    parameter int                OUT_W  = 8,
    parameter int                WARMUP = 33
) (
    input  logic              clk,
    input  logic              res,
    input  logic              ena,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output state_t            fsm_state,
    prng_stream_if.master     stream
);

    localparam int                IDX_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OUT_W - 1);
    localparam logic [7:0]        WARM_LAST = 8'(WARMUP - 1);
    // With no warm-up the generator starts producing bits straight away
    localparam state_t            START     = (WARMUP == 0) ? GEN : WARM;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        warm_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OUT_W-1:0]  asm_q;
    logic [OUT_W-1:0]  dout_q;
    logic              valid_q;

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] load_val;
    logic              shift;
    logic              word_done;
    logic              deliver;
    logic              unpark;
    logic              accept;
    logic [OUT_W-1:0]  word;

    assign accept   = valid_q & stream.dout_ready;
    assign load_val = (seed_in == '0) ? SEED : seed_in;

    prng_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .res      (res),
        .shift    (shift),
        .load     (seed_load),
        .load_val (load_val),
        .value    (lfsr)
    );

    // Assembly word with the current LFSR MSB dropped into slot idx
    always_comb begin
        word        = asm_q;
        word[idx_q] = lfsr[LFSR_W-1];
    end

    // FSM state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; seed_load overrides everything
    always_comb begin
        state_d   = state_q;
        shift     = 1'b0;
        word_done = 1'b0;
        deliver   = 1'b0;
        unpark    = 1'b0;
        if (seed_load) begin
            state_d = START;
        end else begin
            case (state_q)
                WARM: begin
                    if (ena) begin
                        shift = 1'b1;
                        if (warm_q == WARM_LAST) begin
                            state_d = GEN;
                        end
                    end
                end
                GEN: begin
                    if (ena) begin
                        shift = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            word_done = 1'b1;
                            if (!valid_q || accept) begin
                                deliver = 1'b1;
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    // LFSR stays frozen; the parked word leaves once dout is taken
                    if (accept) begin
                        unpark  = 1'b1;
                        state_d = GEN;
                    end
                end
                default: state_d = START;
            endcase
        end
    end

    // Counters, assembly and output registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            warm_q  <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (seed_load) begin
            warm_q  <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state_q == WARM && ena) begin
                warm_q <= warm_q + 8'd1;
            end
            if (state_q == GEN && ena) begin
                asm_q <= word;
                if (word_done) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (deliver) begin
                dout_q  <= word;
                valid_q <= 1'b1;
            end else if (unpark) begin
                dout_q  <= asm_q;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign busy              = (state_q == WARM);
    assign fsm_state         = state_q;
    assign stream.dout       = dout_q;
    assign stream.dout_valid = valid_q;

endmodule

// File: tb/tb_prng_stream.sv
// Bench for prng_stream: scenario table plus hand-written stall/reset cases,
// with a golden LFSR model filling an expected-word queue.
module tb_prng_stream;
    import prng_pkg::*;

    localparam logic [31:0] TB_SEED = 32'd3515;

    logic        clk;
    logic        res;
    logic        ena;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        busy;
    state_t      fsm_state;

    prng_stream_if #(.OUT_W(8)) s_if ();

    prng_stream #(
        .SEED   (TB_SEED),
        .OUT_W  (8),
        .WARMUP (33)
    ) dut (
        .clk       (clk),
        .res       (res),
        .ena       (ena),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .fsm_state (fsm_state),
        .stream    (s_if.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         edge_n = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int          mode;       // 0: reset, 1: seed_load
        logic [31:0] seed;
        logic        tog;        // ena alternates 0/1 when set
        int          exp_busy;   // edge on which busy is first low
        int          exp_first;  // edge on which dout_valid first rises
        int          nw;         // words to check
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Golden model: 33 discarded shifts, then words built LSB first from bit 31
    task automatic push_words(input logic [31:0] seed, input int n);
        logic [31:0] s;
        logic [7:0]  w;
        s = (seed == 32'd0) ? TB_SEED : seed;
        for (int i = 0; i < 33; i++) s = step(s);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                w[b] = s[31];
                s = step(s);
            end
            exp_q.push_back(w);
        end
    endtask

    // Scoreboard: a word is taken on the next edge when valid and ready are both high
    always @(negedge clk) begin
        if (res && s_if.dout_valid && s_if.dout_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", {56'd0, s_if.dout}, 64'hFFFF_FFFF);
            else check("word", {56'd0, s_if.dout}, {56'd0, exp_q.pop_front()});
        end
    end

    // Called just after a rising edge; pulses reset between edges
    task automatic apply_reset();
        res = 1'b0; seed_load = 1'b0; ena = 1'b0; s_if.dout_ready = 1'b0;
        #2;
        check("rst_valid", {63'd0, s_if.dout_valid}, 64'd0);
        check("rst_dout", {56'd0, s_if.dout}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_state", {62'd0, fsm_state}, {62'd0, WARM});
        #1 res = 1'b1;
        edge_n = 0;
    endtask

    task automatic do_seed_load(input logic [31:0] s);
        seed_load = 1'b1; seed_in = s; ena = 1'b0; s_if.dout_ready = 1'b0;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("load_valid", {63'd0, s_if.dout_valid}, 64'd0);
        check("load_dout", {56'd0, s_if.dout}, 64'd0);
        check("load_busy", {63'd0, busy}, 64'd1);
        edge_n = 0;
    endtask

    task automatic warm_to_valid(input logic tog, input logic rdy, input int exp_busy, input int exp_first);
        int busy_at;
        int first_at;
        busy_at = -1;
        first_at = -1;
        s_if.dout_ready = rdy;
        while (first_at < 0 && edge_n < 300) begin
            ena = tog ? ((edge_n + 1) % 2 == 0) : 1'b1;
            @(posedge clk); #1;
            edge_n++;
            if (busy_at < 0 && !busy) busy_at = edge_n;
            if (s_if.dout_valid) first_at = edge_n;
        end
        check("busy_fall", 64'(busy_at), 64'(exp_busy));
        check("first_valid", 64'(first_at), 64'(exp_first));
    endtask

    task automatic drain(input logic tog);
        int guard;
        guard = 0;
        s_if.dout_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 1000) begin
            ena = tog ? ((edge_n + 1) % 2 == 0) : 1'b1;
            @(posedge clk); #1;
            edge_n++;
            guard++;
        end
        check("words_left", 64'(exp_q.size()), 64'd0);
        ena = 1'b0;
        s_if.dout_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        res = 1'b0; ena = 1'b0; seed_load = 1'b0; seed_in = 32'd0;
        s_if.dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        vecs[0] = '{0, 32'd0,         1'b0, 33, 41, 5};
        vecs[1] = '{0, 32'd0,         1'b1, 66, 82, 4};
        vecs[2] = '{1, 32'hDEADBEEF,  1'b0, 33, 41, 5};
        vecs[3] = '{1, 32'd0,         1'b0, 33, 41, 5};

        // Table-driven scenarios; seed loads land mid-stream after the previous case
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].mode == 0) apply_reset();
            else do_seed_load(vecs[v].seed);
            push_words(vecs[v].seed, vecs[v].nw);
            warm_to_valid(vecs[v].tog, 1'b1, vecs[v].exp_busy, vecs[v].exp_first);
            drain(vecs[v].tog);
            @(posedge clk); #1;
        end

        // Consumer stall: second word parks, FSM holds, then releases with ena low
        apply_reset();
        push_words(32'd0, 4);
        warm_to_valid(1'b0, 1'b0, 33, 41);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; edge_n++;
            check("stall_dout", {56'd0, s_if.dout}, {56'd0, exp_q[0]});
            check("stall_state", {62'd0, fsm_state}, {62'd0, GEN});
        end
        @(posedge clk); #1; edge_n++;
        check("hold_enter", {62'd0, fsm_state}, {62'd0, HOLD});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; edge_n++;
            check("hold_dout", {56'd0, s_if.dout}, {56'd0, exp_q[0]});
            check("hold_valid", {63'd0, s_if.dout_valid}, 64'd1);
            check("hold_state", {62'd0, fsm_state}, {62'd0, HOLD});
        end
        ena = 1'b0;
        s_if.dout_ready = 1'b1;
        @(posedge clk); #1; edge_n++;
        check("unpark_state", {62'd0, fsm_state}, {62'd0, GEN});
        check("unpark_valid", {63'd0, s_if.dout_valid}, 64'd1);
        check("unpark_dout", {56'd0, s_if.dout}, {56'd0, exp_q[0]});
        drain(1'b0);
        @(posedge clk); #1;

        // Reset mid-word, then restart must repeat the power-up sequence
        apply_reset();
        push_words(32'd0, 1);
        warm_to_valid(1'b0, 1'b1, 33, 41);
        repeat (4) begin
            @(posedge clk); #1; edge_n++;
        end
        check("pre_reset_words", 64'(exp_q.size()), 64'd0);
        apply_reset();
        push_words(32'd0, 5);
        warm_to_valid(1'b0, 1'b1, 33, 41);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
